// File: rtl/ef_pwm32_shadow_ctrl.sv
// ef_pwm32_shadow_ctrl: double-buffered (shadow/active) cmpA/cmpB/load for the EF 32-bit PWM.
// Latency: an immediate commit updates the actives at the commit edge; an armed commit updates them at the
//          qualifying boundary edge. upd_done pulses in the following cycle.
// Backpressure: none. While a transfer is armed, shadow writes and commits are dropped and flagged in wr_err.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wdata, wr_cmpa/b/load   shadow register write data and per-register write strobes
//   commit, abort           request a shadow->active transfer / cancel an armed transfer
//   upd_mode, sync_cnt      transfer timing: 00 immediate, 01 zero, 10 load, 11 either;
//                           sync_cnt is the number of boundaries to skip. Both are sampled at commit.
//   evt_zero, evt_load      single-cycle boundary strobes from the PWM counter
//   err_clr                 clears the sticky wr_err flag
//   cmpa, cmpb, load        active values driving the PWM
//   pending                 a transfer is armed
//   upd_done                one-cycle pulse after the active values change
//   wr_err                  sticky flag: a write or commit arrived while armed
module ef_pwm32_shadow_ctrl #(
  parameter int unsigned    W        = 32,
  parameter logic [W-1:0]   RST_CMPA = '0,
  parameter logic [W-1:0]   RST_CMPB = '0,
  parameter logic [W-1:0]   RST_LOAD = W'(255)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wdata,
  input  logic         wr_cmpa,
  input  logic         wr_cmpb,
  input  logic         wr_load,
  input  logic         commit,
  input  logic         abort,
  input  logic [1:0]   upd_mode,
  input  logic [3:0]   sync_cnt,
  input  logic         evt_zero,
  input  logic         evt_load,
  input  logic         err_clr,
  output logic [W-1:0] cmpa,
  output logic [W-1:0] cmpb,
  output logic [W-1:0] load,
  output logic         pending,
  output logic         upd_done,
  output logic         wr_err
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [3:0]   skip_q, skip_d;

  logic [W-1:0] sh_cmpa_q, sh_cmpa_d;
  logic [W-1:0] sh_cmpb_q, sh_cmpb_d;
  logic [W-1:0] sh_load_q, sh_load_d;

  logic [W-1:0] act_cmpa_d, act_cmpb_d, act_load_d;

  logic         apply;
  logic         err_set;
  logic         wr_err_d;
  logic         boundary;

  // Write-bypassed shadow values. A write and an immediate commit in the same
  // cycle transfer the freshly written data, not the stale shadow.
  logic [W-1:0] byp_cmpa, byp_cmpb, byp_load;

  assign byp_cmpa = wr_cmpa ? wdata : sh_cmpa_q;
  assign byp_cmpb = wr_cmpb ? wdata : sh_cmpb_q;
  assign byp_load = wr_load ? wdata : sh_load_q;

  // mode_q bit 0 selects the zero boundary and bit 1 the load boundary.
  // If both strobes fire in the same cycle they count as a single boundary.
  assign boundary = (mode_q[0] & evt_zero) | (mode_q[1] & evt_load);

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    skip_d    = skip_q;
    sh_cmpa_d = sh_cmpa_q;
    sh_cmpb_d = sh_cmpb_q;
    sh_load_d = sh_load_q;
    apply     = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        sh_cmpa_d = byp_cmpa;
        sh_cmpb_d = byp_cmpb;
        sh_load_d = byp_load;
        if (commit) begin
          if (upd_mode == 2'b00) begin
            apply = 1'b1;
          end else begin
            state_d = S_ARMED;
            mode_d  = upd_mode;
            skip_d  = sync_cnt;
          end
        end
      end

      S_ARMED: begin
        // Shadows are frozen while armed so that the pending transfer stays
        // coherent. Any attempt to write or commit is dropped and flagged.
        err_set = wr_cmpa | wr_cmpb | wr_load | commit;
        if (abort) begin
          // Abort takes priority over a boundary in the same cycle.
          state_d = S_IDLE;
        end else if (boundary) begin
          if (skip_q == 4'd0) begin
            apply   = 1'b1;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // All three active values load from one decision, so the PWM never sees
    // a partially updated set.
    act_cmpa_d = apply ? sh_cmpa_d : cmpa;
    act_cmpb_d = apply ? sh_cmpb_d : cmpb;
    act_load_d = apply ? sh_load_d : load;

    // A set condition wins over a clear in the same cycle.
    wr_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : wr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'b00;
      skip_q    <= 4'd0;
      sh_cmpa_q <= RST_CMPA;
      sh_cmpb_q <= RST_CMPB;
      sh_load_q <= RST_LOAD;
      cmpa      <= RST_CMPA;
      cmpb      <= RST_CMPB;
      load      <= RST_LOAD;
      upd_done  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      skip_q    <= skip_d;
      sh_cmpa_q <= sh_cmpa_d;
      sh_cmpb_q <= sh_cmpb_d;
      sh_load_q <= sh_load_d;
      cmpa      <= act_cmpa_d;
      cmpb      <= act_cmpb_d;
      load      <= act_load_d;
      upd_done  <= apply;
      wr_err    <= wr_err_d;
    end
  end

  // Cleared at the applying or aborting edge, so it falls in the same cycle
  // that upd_done rises.
  assign pending = (state_q == S_ARMED);

endmodule

// File: tb/tb_ef_pwm32_shadow_ctrl.sv
// Directed testbench for ef_pwm32_shadow_ctrl.
module tb_ef_pwm32_shadow_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] wdata;
  logic         wr_cmpa, wr_cmpb, wr_load;
  logic         commit, abort;
  logic [1:0]   upd_mode;
  logic [3:0]   sync_cnt;
  logic         evt_zero, evt_load;
  logic         err_clr;
  logic [W-1:0] cmpa, cmpb, load;
  logic         pending, upd_done, wr_err;

  int n_chk  = 0;
  int n_fail = 0;

  ef_pwm32_shadow_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata    (wdata),
    .wr_cmpa  (wr_cmpa),
    .wr_cmpb  (wr_cmpb),
    .wr_load  (wr_load),
    .commit   (commit),
    .abort    (abort),
    .upd_mode (upd_mode),
    .sync_cnt (sync_cnt),
    .evt_zero (evt_zero),
    .evt_load (evt_load),
    .err_clr  (err_clr),
    .cmpa     (cmpa),
    .cmpb     (cmpb),
    .load     (load),
    .pending  (pending),
    .upd_done (upd_done),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_cmpa = 0; wr_cmpb = 0; wr_load = 0;
    commit = 0; abort = 0; evt_zero = 0; evt_load = 0; err_clr = 0;
  endtask

  task automatic wr(input int sel, input logic [W-1:0] v);
    wdata = v;
    wr_cmpa = (sel == 0); wr_cmpb = (sel == 1); wr_load = (sel == 2);
    cyc();
    idle_inputs();
  endtask

  task automatic do_commit(input logic [1:0] m, input logic [3:0] s);
    commit = 1; upd_mode = m; sync_cnt = s;
    cyc();
    idle_inputs();
  endtask

  initial begin
    rst_n = 0; wdata = '0; upd_mode = 2'b00; sync_cnt = 4'd0;
    idle_inputs();
    #12;
    chk("rst_cmpa", cmpa, 0);
    chk("rst_cmpb", cmpb, 0);
    chk("rst_load", load, 255);
    chk("rst_pending", pending, 0);
    chk("rst_upd_done", upd_done, 0);
    chk("rst_wr_err", wr_err, 0);
    @(negedge clk); rst_n = 1;
    cyc();

    // Immediate commit, with the load write in the same cycle as the commit.
    wr(0, 40);
    wr(1, 80);
    chk("imm_before_cmpa", cmpa, 0);
    wdata = 100; wr_load = 1; commit = 1; upd_mode = 2'b00;
    cyc();
    idle_inputs();
    chk("imm_cmpa", cmpa, 40);
    chk("imm_cmpb", cmpb, 80);
    chk("imm_load_bypass", load, 100);
    chk("imm_upd_done", upd_done, 1);
    chk("imm_pending", pending, 0);
    cyc();
    chk("imm_upd_done_once", upd_done, 0);

    // Mode 01 (zero boundary) with two boundaries skipped.
    wr(0, 11);
    do_commit(2'b01, 4'd2);
    chk("m01_pending", pending, 1);
    evt_load = 1; cyc(); idle_inputs();
    chk("m01_evt_load_ignored", cmpa, 40);
    for (int i = 0; i < 3; i++) begin
      repeat (9) cyc();
      evt_zero = 1;
      cyc();
      idle_inputs();
      if (i < 2) begin
        chk($sformatf("m01_skip%0d_cmpa", i), cmpa, 40);
        chk($sformatf("m01_skip%0d_pending", i), pending, 1);
        chk($sformatf("m01_skip%0d_done", i), upd_done, 0);
      end else begin
        chk("m01_apply_cmpa", cmpa, 11);
        chk("m01_apply_done", upd_done, 1);
        chk("m01_apply_pending", pending, 0);
      end
    end
    cyc();
    chk("m01_done_once", upd_done, 0);

    // Boundary events while idle do not transfer anything.
    wr(1, 22);
    evt_zero = 1; evt_load = 1; cyc(); idle_inputs();
    chk("idle_evt_cmpb", cmpb, 80);

    // Mode 11: simultaneous zero and load strobes count as a single boundary.
    do_commit(2'b11, 4'd1);
    evt_zero = 1; evt_load = 1; cyc(); idle_inputs();
    chk("m11_both_cmpb", cmpb, 80);
    chk("m11_both_pending", pending, 1);
    repeat (3) cyc();
    evt_load = 1; cyc(); idle_inputs();
    chk("m11_apply_cmpb", cmpb, 22);
    chk("m11_apply_done", upd_done, 1);
    chk("m11_apply_pending", pending, 0);

    // Writes and commits while armed are dropped and flagged.
    wr(0, 33);
    do_commit(2'b10, 4'd0);
    chk("m10_pending", pending, 1);
    wdata = 7; wr_cmpa = 1; commit = 1; cyc(); idle_inputs();
    chk("err_set", wr_err, 1);
    chk("err_still_armed", pending, 1);
    wdata = 7; wr_cmpa = 1; err_clr = 1; cyc(); idle_inputs();
    chk("err_set_beats_clr", wr_err, 1);
    err_clr = 1; cyc(); idle_inputs();
    chk("err_clr", wr_err, 0);

    // Abort has priority over a boundary in the same cycle.
    abort = 1; evt_load = 1; cyc(); idle_inputs();
    chk("abort_pending", pending, 0);
    chk("abort_done", upd_done, 0);
    chk("abort_cmpa", cmpa, 11);
    cyc();
    chk("abort_no_late_done", upd_done, 0);
    abort = 1; cyc(); idle_inputs();
    chk("abort_idle_noop", pending, 0);
    do_commit(2'b00, 4'd0);
    chk("retained_cmpa", cmpa, 33);
    chk("retained_cmpb", cmpb, 22);
    chk("retained_load", load, 100);
    chk("retained_done", upd_done, 1);

    // Asynchronous reset while armed.
    wr(0, 5);
    wr(1, 6);
    wr(2, 7);
    do_commit(2'b01, 4'd0);
    chk("pre_rst_pending", pending, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_cmpa", cmpa, 0);
    chk("arst_cmpb", cmpb, 0);
    chk("arst_load", load, 255);
    chk("arst_pending", pending, 0);
    chk("arst_done", upd_done, 0);
    @(negedge clk); rst_n = 1;
    cyc();
    chk("post_rst_done", upd_done, 0);
    evt_zero = 1; cyc(); idle_inputs();
    chk("post_rst_idle_load", load, 255);
    chk("post_rst_idle_done", upd_done, 0);
    chk("post_rst_pending", pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ef_pwm32_shadow_ctrl.md
Name: ef_pwm32_shadow_ctrl

Overview:
Configuration controller for the EF 32-bit PWM core. It holds double-buffered (shadow/active) copies of cmpA, cmpB and load. Software writes the shadow copies, then a commit transfers them to the active copies that drive the PWM, either immediately or at a selected period boundary. This avoids runt/glitched pulses when duty or period changes mid-cycle. It sits between the register bank and the PWM core; the core supplies single-cycle boundary strobes.

Parameters:
W, 32, width of compare/load values
RST_CMPA, 0, reset value of shadow and active cmpA
RST_CMPB, 0, reset value of shadow and active cmpB
RST_LOAD, 255, reset value of shadow and active load

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
wdata  in  W  write data for shadow registers
wr_cmpa  in  1  strobe: shadow_cmpA <= wdata
wr_cmpb  in  1  strobe: shadow_cmpB <= wdata
wr_load  in  1  strobe: shadow_load <= wdata
commit  in  1  pulse: request shadow->active transfer
abort  in  1  pulse: cancel an armed transfer
upd_mode  in  2  00 immediate, 01 at zero, 10 at load, 11 at zero or load
sync_cnt  in  4  number of qualifying boundaries to skip before applying
evt_zero  in  1  PWM counter==0 strobe, clken-qualified, 1 cycle
evt_load  in  1  PWM counter==load strobe, clken-qualified, 1 cycle
err_clr  in  1  clears wr_err
cmpa  out  W  active cmpA to PWM
cmpb  out  W  active cmpB to PWM
load  out  W  active load to PWM
pending  out  1  high while a transfer is armed
upd_done  out  1  1-cycle pulse, cycle after active values change
wr_err  out  1  sticky: shadow write or commit attempted while armed

Behaviour:
- Reset values:
  - shadows and actives = RST_* values.
  - FSM = IDLE; skip counter = 0.
  - pending, upd_done, wr_err = 0.
- FSM states: IDLE, ARMED.
- IDLE:
  - Shadow write strobes are accepted. Multiple strobes in one cycle each update their own register.
  - commit with upd_mode=00: active <= shadow at the same edge. upd_done=1 the next cycle. Stay IDLE.
  - commit with upd_mode!=00: latch mode into mode_q and sync_cnt into skip counter. Go to ARMED.
  - upd_mode and sync_cnt are sampled only at commit.
- Same-cycle write + commit: the written data is what gets transferred (write bypass into the transfer path).
- ARMED, pending=1:
  - A qualifying boundary is evt_zero (mode 01), evt_load (mode 10), or evt_zero|evt_load (mode 11).
  - Simultaneous evt_zero and evt_load count as one boundary.
  - On a boundary with skip==0: active <= shadow at that edge, go to IDLE, upd_done=1 the next cycle.
  - On a boundary with skip>0: decrement skip.
- ARMED error handling:
  - Any wr_* strobe is dropped (shadow unchanged) and sets wr_err.
  - commit is ignored and sets wr_err.
- abort in ARMED: go to IDLE, no transfer, shadows retained, no upd_done. Abort has priority over a same-cycle boundary. abort in IDLE has no effect.
- wr_err is sticky until err_clr. A set condition in the same cycle as err_clr wins.
- pending deasserts in the cycle after the applying edge, together with upd_done.
- All three active registers update atomically on the same edge. Outputs are never partially updated.
- Boundary events in IDLE are ignored.
- Asynchronous reset mid-ARMED: immediate return to the reset state. No upd_done.
- Shadow and active registers hold full W-bit values; there is no range checking. The skip counter is 4 bits, giving a maximum of 15 skipped boundaries.

Test Plan:
- Reset release → cmpa=0, cmpb=0, load=255, pending=0. Write cmpa=40, cmpb=80, load=100 with mode 00, commit → active = 40/80/100 one edge later; upd_done pulses once.
- Mode 01, sync_cnt=2, commit → pending=1. Pulse evt_zero three times, 10 cycles apart; values unchanged after the first two; update on the third edge; upd_done follows; pending clears.
- Mode 11 with evt_zero and evt_load asserted in the same cycle, sync_cnt=1 → counted as one boundary, no update. The next evt_load applies.
- While ARMED, write wr_cmpa=7 and commit → shadow unchanged, wr_err=1. err_clr together with a new dropped write → wr_err stays 1. err_clr alone → 0.
- ARMED (mode 10), then abort and evt_load in the same cycle → no transfer, pending=0, no upd_done. A later commit with mode 00 transfers the retained shadows.
- Assert rst_n=0 mid-ARMED with shadows = 5/6/7 → outputs return to 0/0/255 asynchronously, pending=0, FSM IDLE; no upd_done after release.
